// File: rtl/exa_crosb_output_vc_scheduler.sv
// Per-output packet scheduler: priority + round-robin arbitration over
// (input, prio, vc) requesters, grant held to footer, downstream credits.
module exa_crosb_output_vc_scheduler #(
  parameter int input_num = 4,
  parameter int vc_num    = 4,
  parameter int prio_num  = 2,
  parameter int CREDITS   = 4,
  parameter int VCP       = prio_num * vc_num,
  parameter int logInput  = (input_num > 1) ? $clog2(input_num) : 1,
  parameter int logVcPrio = (VCP > 1) ? $clog2(VCP) : 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [input_num*VCP-1:0]     i_req,
  input  logic                         i_footer_valid,
  input  logic                         i_footer_ready,
  input  logic [VCP-1:0]               i_credit_return,
  output logic [input_num*VCP-1:0]     o_grant,
  output logic                         o_grant_valid,
  output logic [logInput-1:0]          o_input_sel,
  output logic [logVcPrio-1:0]         o_vcp_sel,
  output logic [VCP*4-1:0]             o_credits,
  output logic                         o_credit_overflow
);

  localparam int NK = input_num * vc_num;
  localparam int NR = input_num * VCP;
  localparam int KW = (NK > 1) ? $clog2(NK) : 1;
  localparam int RW = (NR > 1) ? $clog2(NR) : 1;
  localparam int PW = (prio_num > 1) ? $clog2(prio_num) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_n;

  logic [3:0]    credit [VCP];
  logic [KW-1:0] rr_ptr [prio_num];

  logic [NR-1:0]        elig;
  logic [NR-1:0]        win_vec;
  logic                 found;
  logic [logInput-1:0]  win_in;
  logic [logVcPrio-1:0] win_vcp;
  logic [KW-1:0]        win_k;
  logic [PW-1:0]        win_p;
  logic                 fire;
  logic                 done;

  always_comb begin
    elig = '0;
    for (int r = 0; r < NR; r++)
      elig[r] = i_req[r] && (credit[logVcPrio'(r % VCP)] != 4'd0);
  end

  // Higher priority classes are scanned later so they override lower ones.
  always_comb begin
    int  kk;
    int  idx;
    logic pfound;
    kk      = 0;
    idx     = 0;
    pfound  = 1'b0;
    found   = 1'b0;
    win_vec = '0;
    win_in  = '0;
    win_vcp = '0;
    win_k   = '0;
    win_p   = '0;
    for (int p = 0; p < prio_num; p++) begin
      pfound = 1'b0;
      for (int j = 0; j < NK; j++) begin
        kk  = (int'(rr_ptr[p]) + j) % NK;
        idx = (kk / vc_num) * VCP + p * vc_num + (kk % vc_num);
        if (!pfound && elig[RW'(idx)]) begin
          pfound  = 1'b1;
          found   = 1'b1;
          win_vec = '0;
          win_vec[RW'(idx)] = 1'b1;
          win_in  = logInput'(kk / vc_num);
          win_vcp = logVcPrio'(p * vc_num + (kk % vc_num));
          win_k   = KW'(kk);
          win_p   = PW'(p);
        end
      end
    end
  end

  assign fire = (state == IDLE) && found;
  assign done = (state == BUSY) && i_footer_valid && i_footer_ready;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (found) state_n = BUSY;
      BUSY: if (i_footer_valid && i_footer_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_grant       <= '0;
      o_grant_valid <= 1'b0;
      o_input_sel   <= '0;
      o_vcp_sel     <= '0;
      for (int p = 0; p < prio_num; p++) rr_ptr[p] <= '0;
    end else if (fire) begin
      o_grant       <= win_vec;
      o_grant_valid <= 1'b1;
      o_input_sel   <= win_in;
      o_vcp_sel     <= win_vcp;
      rr_ptr[win_p] <= (win_k == KW'(NK - 1)) ? '0 : win_k + 1'b1;
    end else if (done) begin
      o_grant       <= '0;
      o_grant_valid <= 1'b0;
      o_input_sel   <= '0;
      o_vcp_sel     <= '0;
    end
  end

  // Grant and return on the same class cancel out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_credit_overflow <= 1'b0;
      for (int c = 0; c < VCP; c++) credit[c] <= 4'(CREDITS);
    end else begin
      for (int c = 0; c < VCP; c++) begin
        if (i_credit_return[c] && !(fire && win_vcp == logVcPrio'(c))) begin
          if (credit[c] == 4'(CREDITS)) o_credit_overflow <= 1'b1;
          else                          credit[c] <= credit[c] + 4'd1;
        end else if (!i_credit_return[c] && fire && win_vcp == logVcPrio'(c)) begin
          credit[c] <= credit[c] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    o_credits = '0;
    for (int c = 0; c < VCP; c++) o_credits[4*c +: 4] = credit[c];
  end

endmodule

// File: tb/tb_exa_crosb_output_vc_scheduler.sv
// Directed bench for exa_crosb_output_vc_scheduler: per-cycle vector
// table plus hand sequences for credit corners and mid-packet reset.
module tb_exa_crosb_output_vc_scheduler;

  logic        clk;
  logic        resetn;
  logic [31:0] i_req;
  logic        i_footer_valid;
  logic        i_footer_ready;
  logic [7:0]  i_credit_return;
  logic [31:0] o_grant;
  logic        o_grant_valid;
  logic [1:0]  o_input_sel;
  logic [2:0]  o_vcp_sel;
  logic [31:0] o_credits;
  logic        o_credit_overflow;

  int checks = 0;
  int errors = 0;

  exa_crosb_output_vc_scheduler dut (
    .clk               (clk),
    .resetn            (resetn),
    .i_req             (i_req),
    .i_footer_valid    (i_footer_valid),
    .i_footer_ready    (i_footer_ready),
    .i_credit_return   (i_credit_return),
    .o_grant           (o_grant),
    .o_grant_valid     (o_grant_valid),
    .o_input_sel       (o_input_sel),
    .o_vcp_sel         (o_vcp_sel),
    .o_credits         (o_credits),
    .o_credit_overflow (o_credit_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] req;
    logic        fv;
    logic        fr;
    logic [7:0]  ret;
    logic [31:0] grant;
    logic        gv;
    logic [1:0]  isel;
    logic [2:0]  vsel;
    logic [31:0] cred;
    logic        ovf;
  } vec_t;

  vec_t tq[$];

  task automatic drive(input logic [31:0] req, input logic fv,
                       input logic fr, input logic [7:0] ret);
    i_req           = req;
    i_footer_valid  = fv;
    i_footer_ready  = fr;
    i_credit_return = ret;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] g,
                       input logic gv, input logic [1:0] is,
                       input logic [2:0] vs, input logic [31:0] cr,
                       input logic ov);
    checks++;
    if (o_grant !== g || o_grant_valid !== gv || o_input_sel !== is ||
        o_vcp_sel !== vs || o_credits !== cr || o_credit_overflow !== ov) begin
      errors++;
      $display("FAIL %s: got grant=%h gv=%b isel=%0d vsel=%0d cred=%h ovf=%b, expected grant=%h gv=%b isel=%0d vsel=%0d cred=%h ovf=%b",
               name, o_grant, o_grant_valid, o_input_sel, o_vcp_sel,
               o_credits, o_credit_overflow, g, gv, is, vs, cr, ov);
    end
  endtask

  task automatic add(input logic [31:0] req, input logic fv, input logic fr,
                     input logic [7:0] ret, input logic [31:0] g,
                     input logic gv, input logic [1:0] is,
                     input logic [2:0] vs, input logic [31:0] cr);
    vec_t v;
    v.req = req; v.fv = fv; v.fr = fr; v.ret = ret;
    v.grant = g; v.gv = gv; v.isel = is; v.vsel = vs;
    v.cred = cr; v.ovf = 1'b0;
    tq.push_back(v);
  endtask

  initial begin
    // single request, footer three cycles after grant
    add(32'h1, 0, 0, 8'h00, 32'h1, 1, 0, 0, 32'h44444443);
    add(32'h0, 0, 0, 8'h00, 32'h1, 1, 0, 0, 32'h44444443);
    add(32'h0, 0, 0, 8'h00, 32'h1, 1, 0, 0, 32'h44444443);
    add(32'h0, 1, 1, 8'h00, 32'h0, 0, 0, 0, 32'h44444443);
    add(32'h0, 0, 0, 8'h01, 32'h0, 0, 0, 0, 32'h44444444);
    // round robin on class 1 until credits exhausted
    add(32'h02020202, 0, 0, 8'h00, 32'h00000002, 1, 0, 1, 32'h44444434);
    add(32'h02020202, 1, 1, 8'h00, 32'h0, 0, 0, 0, 32'h44444434);
    add(32'h02020202, 0, 0, 8'h00, 32'h00000200, 1, 1, 1, 32'h44444424);
    add(32'h02020202, 1, 1, 8'h00, 32'h0, 0, 0, 0, 32'h44444424);
    add(32'h02020202, 0, 0, 8'h00, 32'h00020000, 1, 2, 1, 32'h44444414);
    add(32'h02020202, 1, 1, 8'h00, 32'h0, 0, 0, 0, 32'h44444414);
    add(32'h02020202, 0, 0, 8'h00, 32'h02000000, 1, 3, 1, 32'h44444404);
    add(32'h02020202, 1, 1, 8'h00, 32'h0, 0, 0, 0, 32'h44444404);
    add(32'h02020202, 0, 0, 8'h00, 32'h0, 0, 0, 0, 32'h44444404);
    add(32'h02020202, 0, 0, 8'h02, 32'h0, 0, 0, 0, 32'h44444414);
    add(32'h02020202, 0, 0, 8'h00, 32'h00000002, 1, 0, 1, 32'h44444404);
    add(32'h0, 1, 1, 8'h00, 32'h0, 0, 0, 0, 32'h44444404);
    add(32'h0, 0, 0, 8'h02, 32'h0, 0, 0, 0, 32'h44444414);
    add(32'h0, 0, 0, 8'h02, 32'h0, 0, 0, 0, 32'h44444424);
    add(32'h0, 0, 0, 8'h02, 32'h0, 0, 0, 0, 32'h44444434);
    add(32'h0, 0, 0, 8'h02, 32'h0, 0, 0, 0, 32'h44444444);
    // priority, no preemption mid-packet
    add(32'h11, 0, 0, 8'h00, 32'h10, 1, 0, 4, 32'h44434444);
    add(32'h21, 0, 0, 8'h00, 32'h10, 1, 0, 4, 32'h44434444);
    add(32'h21, 1, 1, 8'h00, 32'h0, 0, 0, 0, 32'h44434444);
    add(32'h21, 0, 0, 8'h00, 32'h20, 1, 0, 5, 32'h44334444);
    add(32'h01, 1, 1, 8'h00, 32'h0, 0, 0, 0, 32'h44334444);
    add(32'h01, 0, 0, 8'h00, 32'h1, 1, 0, 0, 32'h44334443);
    add(32'h0, 1, 1, 8'h00, 32'h0, 0, 0, 0, 32'h44334443);
    add(32'h0, 0, 0, 8'h31, 32'h0, 0, 0, 0, 32'h44444444);
    // half handshakes do not release
    add(32'h1, 0, 0, 8'h00, 32'h1, 1, 0, 0, 32'h44444443);
    add(32'h0, 1, 0, 8'h00, 32'h1, 1, 0, 0, 32'h44444443);
    add(32'h0, 0, 1, 8'h00, 32'h1, 1, 0, 0, 32'h44444443);
    add(32'h0, 1, 1, 8'h00, 32'h0, 0, 0, 0, 32'h44444443);
    add(32'h0, 0, 0, 8'h01, 32'h0, 0, 0, 0, 32'h44444444);

    resetn = 1'b0;
    i_req = '0; i_footer_valid = 0; i_footer_ready = 0; i_credit_return = '0;
    #12;
    check("reset", 32'h0, 0, 0, 0, 32'h44444444, 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < tq.size(); i++) begin
      drive(tq[i].req, tq[i].fv, tq[i].fr, tq[i].ret);
      check($sformatf("vec%0d", i), tq[i].grant, tq[i].gv, tq[i].isel,
            tq[i].vsel, tq[i].cred, tq[i].ovf);
    end

    // grant and return on the same class in one cycle
    drive(32'h1, 0, 0, 8'h01);
    check("grant_ret_same", 32'h1, 1, 0, 0, 32'h44444444, 0);
    drive(32'h0, 1, 1, 8'h00);
    check("grant_ret_rel", 32'h0, 0, 0, 0, 32'h44444444, 0);
    drive(32'h0, 0, 0, 8'h01);
    check("overflow_set", 32'h0, 0, 0, 0, 32'h44444444, 1);
    drive(32'h0, 0, 0, 8'h00);
    check("overflow_sticky", 32'h0, 0, 0, 0, 32'h44444444, 1);

    // reset mid-packet with input 2 owning
    resetn = 1'b0;
    #1;
    check("reset2", 32'h0, 0, 0, 0, 32'h44444444, 0);
    @(negedge clk);
    resetn = 1'b1;
    drive(32'h00010000, 0, 0, 8'h00);
    check("in2_grant", 32'h00010000, 1, 2, 0, 32'h44444443, 0);
    #2;
    resetn = 1'b0;
    #1;
    check("async_clear", 32'h0, 0, 0, 0, 32'h44444444, 0);
    @(negedge clk);
    resetn = 1'b1;
    drive(32'h00010001, 0, 0, 8'h00);
    check("rr_after_reset", 32'h1, 1, 0, 0, 32'h44444443, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
